text_console: RTL
=================

Name: text_console

Overview:
- Host-side character writer that fills the 512-byte tile index buffer consumed by the video scan-out block.
- Accepts a byte stream over a valid/ready handshake and drives the buffer's host port (addr/rdwr/cs/wr_data/rd_data).
- Handles cursor placement, control codes, line wrap, screen clear and hardware scroll.
- Layout: 32 columns × 15 rows; cell address = row*32 + col (rows 0..14, addresses 0..479).

Parameters:
- P_cols, 32: characters per row; power of two; the address is {row, col}.
- P_rows, 15: visible text rows.
- P_blank, 8'h20: fill code used by clear and scroll.

Ports:
- G_clock1  in  1  single clock; same clock as the video host port.
- reset  in  1  asynchronous, active-low.
- in_data  in  8  character or control code.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a byte this cycle.
- busy  out  1  clear, scroll or fill in progress.
- cursor_col  out  5  current column, 0..31.
- cursor_row  out  4  current row, 0..14.
- mem_addr  out  9  buffer address.
- mem_rdwr  out  1  1 = read, 0 = write.
- mem_cs  out  1  buffer access strobe.
- mem_wr_data  out  8  write data.
- mem_rd_data  in  8  read data; valid the cycle after a read strobe (1-cycle latency).

Behaviour:
- Clock and reset (already decided): one clock, G_clock1; reset is asynchronous and active-low.
- All outputs are registered.
- Values while reset is low:
  - state = S_CLEAR, index = 0
  - cursor = (0,0), in_ready = 0, busy = 1
  - mem_cs = 0, mem_rdwr = 1, mem_addr = 0, mem_wr_data = 0
- Reset mid-operation aborts any clear or scroll. On release, S_CLEAR restarts from address 0.
- Handshake:
  - A byte is accepted on a cycle where in_valid & in_ready.
  - in_ready = 1 only in S_IDLE and drops the cycle after acceptance.
  - in_data is ignored while in_ready = 0.
- Idle bus: mem_cs = 0, mem_rdwr = 1.
- Every memory access lasts exactly one cycle with mem_cs = 1.
- S_CLEAR: writes P_blank to addresses 0..479, one per cycle (480 cycles). Then cursor = (0,0) and the state goes to S_IDLE.
- S_IDLE, on acceptance, decodes in_data:
  - 0x0D (CR): col = 0. in_ready returns next cycle; no memory access.
  - 0x0A (LF): if row < 14, row + 1 and back to idle next cycle. If row = 14, go to S_SCROLL; row stays 14.
  - 0x08 (BS): if col > 0, col - 1; no erase. At col = 0, no change.
  - 0x0C (FF): go to S_CLEAR; cursor = (0,0) when it finishes.
  - Any other byte: S_PUT.
- S_PUT:
  - One write of {row, col} ← in_data in the cycle after acceptance.
  - Then col + 1. On col = 31, col wraps to 0 and an LF is applied, including scroll at row 14.
  - Printable latency: accept at T, write at T+1, in_ready = 1 at T+2 (no scroll).
- S_SCROLL: copies rows 1..14 up by one row. For i = 0..447, two cycles per byte:
  - S_SCR_RD: cs = 1, rdwr = 1, addr = i + 32.
  - S_SCR_WR: cs = 1, rdwr = 0, addr = i, wr_data = mem_rd_data.
  - Total 896 cycles.
- S_FILL: writes P_blank to addresses 448..479 (32 cycles), then S_IDLE.
- busy = 1 in S_CLEAR, S_SCROLL and S_FILL.
- Address arithmetic is 9-bit with no overflow possible. index counts 0..479 and never reaches 480 on the bus.
- The video side may read concurrently. Tearing during a scroll is accepted.

Decomposition:
- Package video_pkg holds:
  - P_cols, P_rows, the cell count (480) and P_blank
  - control-code constants (CR, LF, BS, FF)
  - typedef enum console_state_t {S_CLEAR, S_IDLE, S_PUT, S_SCR_RD, S_SCR_WR, S_FILL}
- One module, with no sub-module. The buffer itself lives in the video block.

Test Plan:
- Reset release: 480 writes of 0x20 to addresses 0..479 with no gaps; in_ready rises at cycle 481; cursor = (0,0).
- Send 'A' (0x41) at (0,0): one write addr 0 data 0x41 the next cycle; cursor = (1,0); in_ready is low for exactly 1 cycle.
- Send 32 printables on row 3: last write at addr 127; cursor = (0,4); no scroll.
- Cursor at row 14, send LF:
  - bus shows alternating read addr i+32 / write addr i with data passed through (preload a pattern)
  - then 32 writes of 0x20 at 448..479
  - busy is high for 928 cycles; cursor = (col unchanged, 14)
- BS at col 0 leaves col at 0. CR from col 17 gives col 0. FF from (5,9) performs a full clear, then cursor = (0,0).
- Assert reset mid-scroll (i = 100): the bus goes idle immediately; after release a full clear from address 0 occurs.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and state encoding for the text console that writes
// the tile index buffer of the video scan-out block.
package video_pkg;

  localparam int unsigned P_cols  = 32;
  localparam int unsigned P_rows  = 15;
  localparam int unsigned P_cells = P_cols * P_rows;
  localparam logic [7:0]  P_blank = 8'h20;

  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_FF = 8'h0C;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_PUT,
    S_SCR_RD,
    S_SCR_WR,
    S_FILL
  } console_state_t;

endpackage

// File: rtl/text_console.sv
// Byte-stream character writer: cursor handling, control codes, wrap,
// clear and hardware scroll over the buffer's single host port.
module text_console
  import video_pkg::*;
(
  input  logic       G_clock1,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic [4:0] cursor_col,
  output logic [3:0] cursor_row,
  output logic [8:0] mem_addr,
  output logic       mem_rdwr,
  output logic       mem_cs,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data
);

  localparam logic [8:0] LAST_CELL   = 9'(P_cells - 1);
  localparam logic [8:0] SCROLL_LAST = 9'(P_cells - P_cols - 1);
  localparam logic [8:0] ROW_STRIDE  = 9'(P_cols);
  localparam logic [3:0] LAST_ROW    = 4'(P_rows - 1);
  localparam logic [4:0] LAST_COL    = 5'(P_cols - 1);

  console_state_t state_q;
  logic [8:0]     index_q;
  logic [4:0]     col_q;
  logic [3:0]     row_q;
  logic           ready_q;
  logic           busy_q;
  logic           cs_q;
  logic           rdwr_q;
  logic [8:0]     addr_q;
  logic [7:0]     wdata_q;
  logic           scr_wr_q;
  logic           accept;

  assign accept = in_valid & ready_q;

  always_ff @(posedge G_clock1 or negedge reset) begin
    if (!reset) begin
      state_q  <= S_CLEAR;
      index_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      cs_q     <= 1'b0;
      rdwr_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      scr_wr_q <= 1'b0;
    end else begin
      cs_q     <= 1'b0;
      rdwr_q   <= 1'b1;
      scr_wr_q <= 1'b0;
      ready_q  <= 1'b0;
      unique case (state_q)
        S_CLEAR: begin
          cs_q    <= 1'b1;
          rdwr_q  <= 1'b0;
          addr_q  <= index_q;
          wdata_q <= P_blank;
          if (index_q == LAST_CELL) begin
            state_q <= S_IDLE;
            index_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            index_q <= index_q + 9'd1;
          end
        end

        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            case (in_data)
              C_CR: col_q <= '0;
              C_LF: begin
                if (row_q == LAST_ROW) begin
                  state_q <= S_SCR_RD;
                  index_q <= '0;
                  busy_q  <= 1'b1;
                end else begin
                  row_q <= row_q + 4'd1;
                end
              end
              C_BS: begin
                if (col_q != '0) col_q <= col_q - 5'd1;
              end
              C_FF: begin
                state_q <= S_CLEAR;
                index_q <= '0;
                busy_q  <= 1'b1;
              end
              default: begin
                // Character write is issued here so it lands the cycle after acceptance.
                state_q <= S_PUT;
                cs_q    <= 1'b1;
                rdwr_q  <= 1'b0;
                addr_q  <= {row_q, col_q};
                wdata_q <= in_data;
              end
            endcase
          end
        end

        S_PUT: begin
          col_q <= col_q + 5'd1;
          if (col_q == LAST_COL && row_q == LAST_ROW) begin
            state_q <= S_SCR_RD;
            index_q <= '0;
            busy_q  <= 1'b1;
          end else begin
            if (col_q == LAST_COL) row_q <= row_q + 4'd1;
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end

        S_SCR_RD: begin
          cs_q    <= 1'b1;
          rdwr_q  <= 1'b1;
          addr_q  <= index_q + ROW_STRIDE;
          state_q <= S_SCR_WR;
        end

        S_SCR_WR: begin
          cs_q     <= 1'b1;
          rdwr_q   <= 1'b0;
          addr_q   <= index_q;
          scr_wr_q <= 1'b1;
          index_q  <= index_q + 9'd1;
          state_q  <= (index_q == SCROLL_LAST) ? S_FILL : S_SCR_RD;
        end

        S_FILL: begin
          cs_q    <= 1'b1;
          rdwr_q  <= 1'b0;
          addr_q  <= index_q;
          wdata_q <= P_blank;
          if (index_q == LAST_CELL) begin
            state_q <= S_IDLE;
            index_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            index_q <= index_q + 9'd1;
          end
        end

        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign mem_addr   = addr_q;
  assign mem_rdwr   = rdwr_q;
  assign mem_cs     = cs_q;
  // Read data arrives during the scroll-write cycle itself, so it is passed
  // straight through under a registered select; all other data is registered.
  assign mem_wr_data = scr_wr_q ? mem_rd_data : wdata_q;

endmodule
